floor_request_latch: RTL

- Upstream stage of the elevator FSM.
- Debounces and latches the four raw floor buttons into pending requests.
- Presents the pending requests as the `floor_req` bus.
- Runs the door dwell cycle at the served floor and clears each request once it has been served.

---
 rtl/floor_request_latch_pkg.sv | 21 ++
 rtl/floor_request_latch_button_debounce.sv | 45 ++++
 rtl/floor_request_latch.sv | 129 ++++++++++++
 3 files changed

// File: rtl/floor_request_latch_pkg.sv
// Shared constants, state encoding and helpers for the floor request latch.
package floor_request_latch_pkg;

  localparam int NUM_FLOORS          = 4;
  localparam int FLOOR_W             = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_DWELL_CYCLES    = 8;

  typedef enum logic {
    IDLE = 1'b0,
    DOOR = 1'b1
  } state_t;

  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] oh;
    oh    = '0;
    oh[f] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/floor_request_latch_button_debounce.sv
// One button: 2-flop synchronizer, saturating debounce counter, single press pulse.
// Pulse appears DEBOUNCE_CYCLES+1 cycles after the raw input rises; no backpressure.
module button_debounce
  import floor_request_latch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter parks at CNT_MAX so a held button fires exactly once.
  always_comb begin
    cnt_d = cnt_q;
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign press_o = sync2_q && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/floor_request_latch.sv
// Debounces floor buttons into pending requests and runs the door dwell at the served floor.
// floor_req is masked while the door is open; EMERGENCY_CLEAR_EN drops all requests on emergency.
module floor_request_latch
  import floor_request_latch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DWELL_CYCLES    = DEF_DWELL_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] btn,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  motor_stop,
  input  logic                  emergency_stop,
  output logic [NUM_FLOORS-1:0] floor_req,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open
);

  localparam int DWELL_W = $clog2(DWELL_CYCLES);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  logic [NUM_FLOORS-1:0] press;

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (btn[g]),
      .press_o(press[g])
    );
  end

  state_t                state_q, state_d;
  logic [DWELL_W-1:0]    dwell_q, dwell_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [NUM_FLOORS-1:0] set_mask, clr_mask;
  logic                  abort_hold;

`ifdef EMERGENCY_CLEAR_EN
  logic estop_q, rise_q, abort_q, abort_d;

  assign abort_hold = abort_q;
`else
  assign abort_hold = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    floor_d  = floor_q;
    set_mask = press;
    clr_mask = '0;

    case (state_q)
      IDLE: begin
        if (motor_stop && !emergency_stop && pending_q[current_floor]) begin
          state_d = DOOR;
          dwell_d = '0;
          floor_d = current_floor;
        end
      end
      DOOR: begin
        // A press for the served floor reopens the door instead of re-latching.
        set_mask = press & ~floor_onehot(floor_q);
        if (abort_hold) begin
          if (!emergency_stop) begin
            state_d = IDLE;
          end
        end else if (press[floor_q]) begin
          dwell_d = '0;
        end else if (emergency_stop) begin
          dwell_d = dwell_q;
        end else if (dwell_q == DWELL_LAST) begin
          clr_mask = floor_onehot(floor_q);
          state_d  = IDLE;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    pending_d = (pending_q | set_mask) & ~clr_mask;

`ifdef EMERGENCY_CLEAR_EN
    if (rise_q) begin
      pending_d = '0;
    end
    abort_d = (state_d == DOOR) && (abort_q || rise_q);
`endif
  end

  assign floor_req = (state_q == IDLE) ? pending_q : '0;
  assign pending   = pending_q;
  assign door_open = (state_q == DOOR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      dwell_q   <= '0;
      floor_q   <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
    end
  end

`ifdef EMERGENCY_CLEAR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estop_q <= 1'b0;
      rise_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      estop_q <= emergency_stop;
      rise_q  <= emergency_stop && !estop_q;
      abort_q <= abort_d;
    end
  end
`endif

endmodule
